// File: rtl/dht_ascii_framer_if.sv
// dht_ascii_framer_if
//   Bundles the reading bus from the DHT11 reader and the byte handshake
//   with the UART transmitter into one port.
//
//   Reading side: hum_int/hum_dec/temp_int/temp_dec/checksum_ok are valid
//   only in the cycle where data_valid is 1.
//   UART side: senddata is a one-cycle request. txbyte is stable from the
//   edge that raises senddata until the UART's txdone pulse is sampled.
//   A txdone that arrives while no byte is outstanding is ignored.
//   Status: busy is high while a line is in progress. drop pulses one cycle
//   after a data_valid that arrived while busy.
//   dbg_state mirrors the framer FSM (0 IDLE, 1 CONV, 2 SEND, 3 WAIT).
//
//   modport slave  : the framer
//   modport master : the environment (reader + UART)
interface dht_ascii_framer_if;
  logic [7:0] hum_int;
  logic [7:0] hum_dec;
  logic [7:0] temp_int;
  logic [7:0] temp_dec;
  logic       checksum_ok;
  logic       data_valid;
  logic       txdone;
  logic [7:0] txbyte;
  logic       senddata;
  logic       busy;
  logic       drop;
  logic [1:0] dbg_state;

  modport slave (
    input  hum_int, hum_dec, temp_int, temp_dec, checksum_ok, data_valid, txdone,
    output txbyte, senddata, busy, drop, dbg_state
  );

  modport master (
    output hum_int, hum_dec, temp_int, temp_dec, checksum_ok, data_valid, txdone,
    input  txbyte, senddata, busy, drop, dbg_state
  );
endinterface

// File: rtl/dht_ascii_framer.sv
// dht_ascii_framer
//   Turns one DHT11 reading into an ASCII line and streams it to a UART TX.
//   Valid reading : "H=hhh.d T=ttt.d\r\n" (17 bytes, integers zero padded,
//                   decimal digit clamped to 9)
//   Checksum error: "ERR\r\n" (5 bytes)
//   The integer bytes are converted to BCD by an 8-cycle double-dabble that
//   runs for both kinds of line, so every line starts 8 cycles after capture.
//
//   Ports:
//     clk  - system clock, rising edge
//     rst  - asynchronous, active-high reset
//     bus  - dht_ascii_framer_if.slave (reading in, UART handshake out, status)
module dht_ascii_framer #(
  parameter int LINE_LEN = 17,
  parameter int ERR_LEN  = 5
) (
  input logic               clk,
  input logic               rst,
  dht_ascii_framer_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    SEND = 2'd2,
    WAIT = 2'd3
  } state_t;

  localparam logic [4:0] LAST_OK  = 5'(LINE_LEN - 1);
  localparam logic [4:0] LAST_ERR = 5'(ERR_LEN - 1);

  state_t      state, state_nx;
  // Shift registers: [19:8] BCD hundreds/tens/ones, [7:0] binary still to shift
  logic [19:0] hum_sr, temp_sr;
  logic [7:0]  hum_dec_q, temp_dec_q;
  logic        ok_q;
  logic [2:0]  bit_cnt;
  logic [4:0]  idx;
  logic [7:0]  txbyte_q;
  logic        senddata_q, busy_q, drop_q;

  logic        conv_done, last_byte, load;
  logic [4:0]  idx_nx;
  logic [7:0]  byte_nx;

  // One double-dabble iteration: add 3 to any BCD digit >= 5, then shift.
  function automatic logic [19:0] dd_step(input logic [19:0] v);
    logic [19:0] t;
    t = v;
    for (int d = 0; d < 3; d++) begin
      if (t[8 + 4*d +: 4] >= 4'd5) t[8 + 4*d +: 4] = t[8 + 4*d +: 4] + 4'd3;
    end
    return {t[18:0], 1'b0};
  endfunction

  function automatic logic [7:0] digit(input logic [3:0] d);
    return {4'h3, d};
  endfunction

  function automatic logic [7:0] dec_digit(input logic [7:0] d);
    return (d > 8'd9) ? 8'h39 : {4'h3, d[3:0]};
  endfunction

  assign conv_done = (state == CONV) && (bit_cnt == 3'd7);
  assign last_byte = (idx == (ok_q ? LAST_OK : LAST_ERR));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (bus.data_valid) state_nx = CONV;
      CONV: if (conv_done) state_nx = SEND;
      SEND: state_nx = WAIT;
      WAIT: if (bus.txdone) state_nx = last_byte ? IDLE : SEND;
      default: state_nx = IDLE;
    endcase
  end

  // Output logic: when to load a byte, which index, and its ASCII value
  always_comb begin
    load    = conv_done || ((state == WAIT) && bus.txdone && !last_byte);
    idx_nx  = (state == CONV) ? 5'd0 : idx + 5'd1;
    byte_nx = 8'h00;
    if (ok_q) begin
      case (idx_nx)
        5'd0:    byte_nx = 8'h48;
        5'd1:    byte_nx = 8'h3D;
        5'd2:    byte_nx = digit(hum_sr[19:16]);
        5'd3:    byte_nx = digit(hum_sr[15:12]);
        5'd4:    byte_nx = digit(hum_sr[11:8]);
        5'd5:    byte_nx = 8'h2E;
        5'd6:    byte_nx = dec_digit(hum_dec_q);
        5'd7:    byte_nx = 8'h20;
        5'd8:    byte_nx = 8'h54;
        5'd9:    byte_nx = 8'h3D;
        5'd10:   byte_nx = digit(temp_sr[19:16]);
        5'd11:   byte_nx = digit(temp_sr[15:12]);
        5'd12:   byte_nx = digit(temp_sr[11:8]);
        5'd13:   byte_nx = 8'h2E;
        5'd14:   byte_nx = dec_digit(temp_dec_q);
        5'd15:   byte_nx = 8'h0D;
        5'd16:   byte_nx = 8'h0A;
        default: byte_nx = 8'h00;
      endcase
    end else begin
      case (idx_nx)
        5'd0:    byte_nx = 8'h45;
        5'd1:    byte_nx = 8'h52;
        5'd2:    byte_nx = 8'h52;
        5'd3:    byte_nx = 8'h0D;
        5'd4:    byte_nx = 8'h0A;
        default: byte_nx = 8'h00;
      endcase
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hum_sr     <= '0;
      temp_sr    <= '0;
      hum_dec_q  <= '0;
      temp_dec_q <= '0;
      ok_q       <= 1'b0;
      bit_cnt    <= '0;
      idx        <= '0;
      txbyte_q   <= '0;
      senddata_q <= 1'b0;
      busy_q     <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      // busy is still 1 on the edge that returns to IDLE, so a reading
      // arriving exactly then is dropped rather than captured.
      drop_q     <= bus.data_valid & busy_q;
      senddata_q <= load;
      if (load) begin
        txbyte_q <= byte_nx;
        idx      <= idx_nx;
      end
      case (state)
        IDLE: if (bus.data_valid) begin
          hum_sr     <= {12'd0, bus.hum_int};
          temp_sr    <= {12'd0, bus.temp_int};
          hum_dec_q  <= bus.hum_dec;
          temp_dec_q <= bus.temp_dec;
          ok_q       <= bus.checksum_ok;
          bit_cnt    <= 3'd0;
          busy_q     <= 1'b1;
        end
        CONV: begin
          hum_sr  <= dd_step(hum_sr);
          temp_sr <= dd_step(temp_sr);
          bit_cnt <= bit_cnt + 3'd1;
        end
        WAIT: if (bus.txdone && last_byte) busy_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.txbyte    = txbyte_q;
  assign bus.senddata  = senddata_q;
  assign bus.busy      = busy_q;
  assign bus.drop      = drop_q;
  assign bus.dbg_state = state;
endmodule

// File: tb/tb_dht_ascii_framer.sv
// tb_dht_ascii_framer
//   Directed + randomized bench for dht_ascii_framer. A UART model answers
//   each senddata with a txdone after a fixed or random delay; accepted bytes
//   are scored against a queue filled from a line model built with plain
//   decimal arithmetic.
module tb_dht_ascii_framer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dht_ascii_framer_if ifc();
  logic uart_done = 1'b0;
  logic spur_done = 1'b0;
  assign ifc.txdone = uart_done | spur_done;

  dht_ascii_framer dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  logic [7:0] exp_q[$];
  int n_vec  = 0;
  int n_err  = 0;
  int n_send = 0;

  bit         uart_rand  = 1'b0;
  int         uart_delay = 11;
  bit         u_active   = 1'b0;
  int         u_cnt      = 0;
  logic [7:0] u_byte;
  logic [7:0] u_exp;
  bit         u_bad      = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference line model
  function automatic logic [7:0] asc_dig(input int v);
    return 8'(8'h30 + v);
  endfunction

  task automatic push_line(input logic [7:0] hi, hd, ti, td, input bit ok);
    if (!ok) begin
      exp_q.push_back(8'h45); exp_q.push_back(8'h52); exp_q.push_back(8'h52);
      exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
    end else begin
      exp_q.push_back(8'h48); exp_q.push_back(8'h3D);
      exp_q.push_back(asc_dig(int'(hi) / 100));
      exp_q.push_back(asc_dig((int'(hi) / 10) % 10));
      exp_q.push_back(asc_dig(int'(hi) % 10));
      exp_q.push_back(8'h2E);
      exp_q.push_back(asc_dig((hd > 9) ? 9 : int'(hd)));
      exp_q.push_back(8'h20);
      exp_q.push_back(8'h54); exp_q.push_back(8'h3D);
      exp_q.push_back(asc_dig(int'(ti) / 100));
      exp_q.push_back(asc_dig((int'(ti) / 10) % 10));
      exp_q.push_back(asc_dig(int'(ti) % 10));
      exp_q.push_back(8'h2E);
      exp_q.push_back(asc_dig((td > 9) ? 9 : int'(td)));
      exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
    end
  endtask

  // UART model + scoreboard
  always @(negedge clk) begin
    uart_done = 1'b0;
    if (rst) begin
      u_active = 1'b0;
    end else if (u_active) begin
      if (ifc.senddata !== 1'b0 || ifc.txbyte !== u_byte) u_bad = 1'b1;
      u_cnt--;
      if (u_cnt == 0) begin
        chk("txbyte_hold_single_send", {31'd0, u_bad}, 32'd0);
        uart_done = 1'b1;
        u_active  = 1'b0;
      end
    end else if (ifc.senddata === 1'b1) begin
      u_byte = ifc.txbyte;
      n_send++;
      u_bad    = 1'b0;
      u_active = 1'b1;
      u_cnt    = uart_rand ? int'($urandom_range(1, 40)) : uart_delay;
      u_exp    = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      chk("byte", {24'd0, u_byte}, {24'd0, u_exp});
    end
  end

  // Drive one reading and check the 8-cycle conversion window.
  task automatic apply(input logic [7:0] hi, hd, ti, td, input bit ok, input bit spur,
                       output int c0);
    if (spur) begin
      for (int i = 0; i < 4; i++) begin
        spur_done = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
    end
    spur_done       = 1'b0;
    ifc.hum_int     = hi;
    ifc.hum_dec     = hd;
    ifc.temp_int    = ti;
    ifc.temp_dec    = td;
    ifc.checksum_ok = ok;
    ifc.data_valid  = 1'b1;
    @(negedge clk);
    ifc.data_valid  = 1'b0;
    ifc.hum_int     = 8'($urandom);
    ifc.temp_int    = 8'($urandom);
    ifc.checksum_ok = 1'($urandom_range(0, 1));
    c0 = cyc;
    chk("busy_after_capture", {31'd0, ifc.busy}, 32'd1);
    for (int i = 1; i <= 8; i++) begin
      spur_done = (spur && i <= 6) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      if (i < 8) begin
        chk("senddata_during_conv", {31'd0, ifc.senddata}, 32'd0);
      end else begin
        chk("senddata_first", {31'd0, ifc.senddata}, 32'd1);
        chk("txbyte_first", {24'd0, ifc.txbyte}, ok ? 32'h48 : 32'h45);
      end
    end
    spur_done = 1'b0;
  endtask

  task automatic wait_idle(output int c1);
    int k;
    k = 0;
    while (ifc.busy === 1'b1 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    c1 = cyc;
    chk("line_end_busy", {31'd0, ifc.busy}, 32'd0);
  endtask

  task automatic run_line(input logic [7:0] hi, hd, ti, td, input bit ok, input bit spur);
    int base, c0, c1;
    base = n_send;
    push_line(hi, hd, ti, td, ok);
    apply(hi, hd, ti, td, ok, spur, c0);
    wait_idle(c1);
    chk("line_bytes", 32'(n_send - base), ok ? 32'd17 : 32'd5);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int         base, c0, c1, k;
    logic [7:0] line45 [17];
    line45 = '{8'h48, 8'h3D, 8'h30, 8'h34, 8'h35, 8'h2E, 8'h30, 8'h20, 8'h54,
               8'h3D, 8'h30, 8'h32, 8'h33, 8'h2E, 8'h35, 8'h0D, 8'h0A};
    ifc.hum_int = '0; ifc.hum_dec = '0; ifc.temp_int = '0; ifc.temp_dec = '0;
    ifc.checksum_ok = 1'b0; ifc.data_valid = 1'b0;

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_txbyte",   {24'd0, ifc.txbyte},   32'd0);
    chk("reset_senddata", {31'd0, ifc.senddata}, 32'd0);
    chk("reset_busy",     {31'd0, ifc.busy},     32'd0);
    chk("reset_drop",     {31'd0, ifc.drop},     32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Normal reading 45.0 / 23.5 against the literal byte string, with timing
    for (int i = 0; i < 17; i++) exp_q.push_back(line45[i]);
    base = n_send;
    apply(8'd45, 8'd0, 8'd23, 8'd5, 1'b1, 1'b0, c0);
    wait_idle(c1);
    chk("line_cycles", 32'(c1 - c0), 32'd212);
    chk("normal_bytes", 32'(n_send - base), 32'd17);
    chk("normal_queue", 32'(exp_q.size()), 32'd0);
    chk("txbyte_held_idle", {24'd0, ifc.txbyte}, 32'h0A);

    // Checksum failure and extremes
    run_line(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b0);
    run_line(8'd0, 8'd0, 8'd255, 8'd12, 1'b1, 1'b0);
    run_line(8'd9, 8'd9, 8'd100, 8'd10, 1'b1, 1'b0);

    // Overrun: second reading 20 cycles into a line
    base = n_send;
    push_line(8'd61, 8'd3, 8'd199, 8'd7, 1'b1);
    apply(8'd61, 8'd3, 8'd199, 8'd7, 1'b1, 1'b0, c0);
    repeat (12) @(negedge clk);
    ifc.hum_int = 8'd77; ifc.checksum_ok = 1'b0; ifc.data_valid = 1'b1;
    @(negedge clk);
    ifc.data_valid = 1'b0;
    chk("drop_pulse", {31'd0, ifc.drop}, 32'd1);
    @(negedge clk);
    chk("drop_single", {31'd0, ifc.drop}, 32'd0);
    wait_idle(c1);
    repeat (30) @(negedge clk);
    chk("overrun_bytes", 32'(n_send - base), 32'd17);
    chk("overrun_queue", 32'(exp_q.size()), 32'd0);
    chk("overrun_no_second_line", {31'd0, ifc.busy}, 32'd0);

    // Reset during WAIT of byte 6
    base = n_send;
    push_line(8'd45, 8'd0, 8'd23, 8'd5, 1'b1);
    apply(8'd45, 8'd0, 8'd23, 8'd5, 1'b1, 1'b0, c0);
    k = 0;
    while (n_send - base < 7 && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk("reached_byte6", 32'(n_send - base), 32'd7);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midreset_senddata", {31'd0, ifc.senddata}, 32'd0);
    chk("midreset_busy",     {31'd0, ifc.busy},     32'd0);
    chk("midreset_txbyte",   {24'd0, ifc.txbyte},   32'd0);
    @(negedge clk);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_line(8'd87, 8'd4, 8'd31, 8'd0, 1'b1, 1'b0);

    // Handshake stress: random txdone delay, spurious txdone in IDLE/CONV
    uart_rand = 1'b1;
    for (int n = 0; n < 6; n++) begin
      run_line(8'($urandom_range(0, 255)), 8'($urandom_range(0, 15)),
               8'($urandom_range(0, 255)), 8'($urandom_range(0, 15)),
               ($urandom_range(0, 3) != 0), 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
